moore_seq_det: RTL and testbench
================================

MOORE_SEQ_DET -- requirements
Module: moore_seq_det

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning pattern length in bits (legal 2..16).
REQ-002 The block SHALL have parameter PATTERN, default 4'b1101, N bits wide, meaning the target sequence; PATTERN[N-1] is received first.
REQ-003 The block SHALL have parameter OVERLAP, default 1, where 1 = overlapping detection and 0 = non-overlapping.
REQ-004 The block SHALL have parameter CNT_W, default 8, meaning match counter width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port din, input, 1 bit: serial data bit, sampled only when en=1.
REQ-008 The block SHALL have port en, input, 1 bit: sample qualifier; while en=0 all state and outputs hold.
REQ-009 The block SHALL have port dout, output, 1 bit: Moore detect flag, high iff the FSM is in state S_N.
REQ-010 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of detections.
REQ-011 The block SHALL have port state_o, output, $clog2(N+1) bits: current state index, for debug.

Function
REQ-012 The FSM SHALL have N+1 states S_0..S_N, where S_k means the last k sampled bits equal PATTERN[N-1:N-k] and k is the longest such prefix.
REQ-013 On an edge with en=1 from S_k (k<N), next state SHALL be the longest prefix of PATTERN that is a suffix of (matched prefix k bits, din); the k+1 match advances to S_(k+1).
REQ-014 With OVERLAP=1, from S_N the next state SHALL be computed as in REQ-013, using the full N-bit match as history (failure-function fallback).
REQ-015 With OVERLAP=0, from S_N the next state SHALL be S_1 if din==PATTERN[N-1], else S_0; no bits of the completed match are reused.
REQ-016 dout SHALL be a pure function of the registered state; there is no combinational path from din to dout.
REQ-017 Latency: dout SHALL rise in the cycle immediately after the edge that samples the final pattern bit with en=1.
REQ-018 If en=0 while in S_N, dout SHALL remain high until the next en=1 edge moves the state.
REQ-019 Consecutive matches in overlap mode, for example PATTERN=1111, SHALL keep dout high across cycles (S_N to S_N).
REQ-020 Transition tables SHALL be derived at elaboration time from N, PATTERN and OVERLAP; there SHALL be no per-pattern hand coding.
REQ-021 Parameter values outside the legal range SHALL be flagged at elaboration time, by simulation $error or an equivalent mechanism.

Reset
REQ-022 When rst=1 at a rising clk edge, state SHALL become S_0, dout 0, and match_cnt 0, regardless of en or din.
REQ-023 rst SHALL take priority over en; a reset mid-sequence SHALL discard any partial match.
REQ-024 The first sample after reset is released SHALL be evaluated from S_0.

Configuration
REQ-025 Macro MOORE_SEQ_MATCH_CNT_EN SHALL select whether the match counter is built.
REQ-026 With MOORE_SEQ_MATCH_CNT_EN defined, match_cnt SHALL increment by 1 on every en=1 edge whose next state is S_N.
REQ-027 With MOORE_SEQ_MATCH_CNT_EN defined, match_cnt SHALL saturate at 2^CNT_W-1 and hold there.
REQ-028 With MOORE_SEQ_MATCH_CNT_EN undefined, match_cnt SHALL be tied to constant 0, no counter flops SHALL exist, and FSM behaviour SHALL be unchanged.

Verification
REQ-029 Defaults, reset then en=1 with din stream 1,1,0,1,1,0,1 -> dout high one cycle after the 4th bit and one cycle after the 7th bit; match_cnt=2.
REQ-030 OVERLAP=0, same stream as REQ-029 -> dout high only after the 4th bit; match_cnt=1.
REQ-031 Defaults, stream 1,1,0 then en=0 for 3 cycles then en=1 din=1 -> no change during the hold, then dout=1; after the match, en=0 keeps dout=1.
REQ-032 Defaults, stream 1,1,0, then rst=1 for one cycle, then 1 -> state_o=1 and dout=0 (partial match discarded).
REQ-033 N=4, PATTERN=4'b1111, OVERLAP=1, CNT_W=2, din=1 for 8 en cycles -> dout high from cycle 4 onward; match_cnt saturates at 3.
REQ-034 Build without MOORE_SEQ_MATCH_CNT_EN and rerun REQ-029 -> identical dout trace; match_cnt=0 throughout.

Source files
------------

// File: rtl/moore_seq_det.sv
// Moore serial pattern detector with an elaboration-time transition table.
// Define MOORE_SEQ_MATCH_CNT_EN to build the saturating match counter.
module moore_seq_det #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1101,
  parameter int             OVERLAP = 1,
  parameter int             CNT_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din,
  input  logic                       en,
  output logic                       dout,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [$clog2(N+1)-1:0]     state_o
);

  localparam int SW    = $clog2(N + 1);
  localparam int TBL_W = 2 * (2 ** SW) * SW;
  localparam logic [SW-1:0] S_0 = '0;
  localparam logic [SW-1:0] S_N = SW'(N);

  typedef logic [SW-1:0] state_t;

  if (N < 2 || N > 16) begin : g_bad_n
    $error("moore_seq_det: N=%0d outside legal range 2..16", N);
  end
  if (OVERLAP != 0 && OVERLAP != 1) begin : g_bad_overlap
    $error("moore_seq_det: OVERLAP=%0d must be 0 or 1", OVERLAP);
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("moore_seq_det: CNT_W=%0d must be at least 1", CNT_W);
  end

  // Entry {k, bit} holds the longest pattern prefix that is a suffix of
  // (matched prefix of length k, bit). Unreachable codes fall back to S_0.
  function automatic logic [TBL_W-1:0] build_table();
    logic [TBL_W-1:0] t;
    logic [16:0]      hist;
    int               len;
    int               best;
    logic             ok;
    t = '0;
    for (int k = 0; k <= N; k++) begin
      for (int b = 0; b < 2; b++) begin
        best = 0;
        if (k == N && OVERLAP == 0) begin
          best = (b == int'(PATTERN[N-1])) ? 1 : 0;
        end else begin
          // hist[0] is the newest bit, hist[k] the oldest matched bit
          hist    = '0;
          hist[0] = b[0];
          for (int i = 1; i <= k; i++) hist[i] = PATTERN[N-k+i-1];
          len = (k + 1 > N) ? N : k + 1;
          for (int j = 1; j <= len; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
              if (hist[i] != PATTERN[N-j+i]) ok = 1'b0;
            end
            if (ok) best = j;
          end
        end
        t[(2*k+b)*SW +: SW] = SW'(best);
      end
    end
    return t;
  endfunction

  localparam logic [TBL_W-1:0] TABLE = build_table();

  state_t        state;
  state_t        next_state;
  logic [SW:0]   sel;

  always_ff @(posedge clk) begin
    if (rst) state <= S_0;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    sel        = {state, din};
    if (en) next_state = TABLE[int'(sel)*SW +: SW];
    dout = (state == S_N);
  end

  assign state_o = state;

`ifdef MOORE_SEQ_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en && next_state == S_N && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_cnt = cnt;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_moore_seq_det.sv
// Scoreboard bench for moore_seq_det: defaults, non-overlap, and all-ones
// saturating variants driven with hand-computed directed vectors.
module tb_moore_seq_det;

  localparam int W = 22;  // {step[7:0], id[1:0], dout, state[2:0], cnt[7:0]}

  logic       clk;
  logic [2:0] rst;
  logic [2:0] en;
  logic [2:0] din;

  logic       dout0, dout1, dout2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic [2:0] st0, st1, st2;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;
  int step_no;
  bit stim_done;

  moore_seq_det u_dut0 (
    .clk(clk), .rst(rst[0]), .din(din[0]), .en(en[0]),
    .dout(dout0), .match_cnt(cnt0), .state_o(st0)
  );

  moore_seq_det #(.OVERLAP(0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .din(din[1]), .en(en[1]),
    .dout(dout1), .match_cnt(cnt1), .state_o(st1)
  );

  moore_seq_det #(.N(4), .PATTERN(4'b1111), .OVERLAP(1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst[2]), .din(din[2]), .en(en[2]),
    .dout(dout2), .match_cnt(cnt2), .state_o(st2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected count is zero when the counter is not built
  function automatic int c(input int x);
`ifdef MOORE_SEQ_MATCH_CNT_EN
    return x;
`else
    return 0 * x;
`endif
  endfunction

  // driver: apply one edge's inputs to one DUT, push the post-edge expectation
  task automatic step(input int id, input logic r, input logic e, input logic d,
                      input logic xd, input int xs, input int xc);
    logic [W-1:0] entry;
    @(negedge clk);
    rst = 3'b000;
    en  = 3'b000;
    din = 3'b000;
    rst[id] = r;
    en[id]  = e;
    din[id] = d;
    @(posedge clk);
    #1;
    step_no = step_no + 1;
    entry = {step_no[7:0], id[1:0], xd, xs[2:0], xc[7:0]};
    exp_q.push_back(entry);
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] e;
    logic [7:0]   a_cnt;
    logic [2:0]   a_st;
    logic         a_d;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        case (e[13:12])
          2'd0:    begin a_d = dout0; a_st = st0; a_cnt = cnt0; end
          2'd1:    begin a_d = dout1; a_st = st1; a_cnt = cnt1; end
          default: begin a_d = dout2; a_st = st2; a_cnt = {6'b0, cnt2}; end
        endcase
        checks = checks + 1;
        if (a_d !== e[11] || a_st !== e[10:8] || a_cnt !== e[7:0]) begin
          errors = errors + 1;
          $display("FAIL step%0d dut%0d: got dout=%b state=%0d cnt=%0d, want dout=%b state=%0d cnt=%0d",
                   e[21:14], e[13:12], a_d, a_st, a_cnt, e[11], e[10:8], e[7:0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    checks = 0; errors = 0; step_no = 0; stim_done = 1'b0;
    rst = 3'b111; en = 3'b000; din = 3'b000;
    repeat (2) @(posedge clk);

    // defaults, overlapping 1101: stream 1,1,0,1,1,0,1 then 0 from S_N
    step(0, 1, 1, 1, 0, 0, c(0));
    step(0, 0, 1, 1, 0, 1, c(0));
    step(0, 0, 1, 1, 0, 2, c(0));
    step(0, 0, 1, 0, 0, 3, c(0));
    step(0, 0, 1, 1, 1, 4, c(1));
    step(0, 0, 1, 1, 0, 2, c(1));
    step(0, 0, 1, 0, 0, 3, c(1));
    step(0, 0, 1, 1, 1, 4, c(2));
    step(0, 0, 1, 0, 0, 0, c(2));

    // hold with en=0 (din=1 must be ignored), then complete; en=0 keeps dout
    step(0, 1, 0, 0, 0, 0, c(0));
    step(0, 0, 1, 1, 0, 1, c(0));
    step(0, 0, 1, 1, 0, 2, c(0));
    step(0, 0, 1, 0, 0, 3, c(0));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 3, c(0));
    step(0, 0, 1, 1, 1, 4, c(1));
    step(0, 0, 0, 0, 1, 4, c(1));
    step(0, 0, 0, 1, 1, 4, c(1));

    // reset mid-sequence discards the partial match and the count
    step(0, 0, 1, 1, 0, 2, c(1));
    step(0, 0, 1, 0, 0, 3, c(1));
    step(0, 1, 1, 1, 0, 0, c(0));
    step(0, 0, 1, 1, 0, 1, c(0));

    // non-overlapping 1101: only the first match counts
    step(1, 1, 0, 0, 0, 0, c(0));
    step(1, 0, 1, 1, 0, 1, c(0));
    step(1, 0, 1, 1, 0, 2, c(0));
    step(1, 0, 1, 0, 0, 3, c(0));
    step(1, 0, 1, 1, 1, 4, c(1));
    step(1, 0, 1, 1, 0, 1, c(1));
    step(1, 0, 1, 0, 0, 0, c(1));
    step(1, 0, 1, 1, 0, 1, c(1));

    // all-ones pattern, 2-bit counter saturates at 3
    step(2, 1, 0, 0, 0, 0, c(0));
    step(2, 0, 1, 1, 0, 1, c(0));
    step(2, 0, 1, 1, 0, 2, c(0));
    step(2, 0, 1, 1, 0, 3, c(0));
    step(2, 0, 1, 1, 1, 4, c(1));
    step(2, 0, 1, 1, 1, 4, c(2));
    step(2, 0, 1, 1, 1, 4, c(3));
    step(2, 0, 1, 1, 1, 4, c(3));
    step(2, 0, 1, 1, 1, 4, c(3));
    step(2, 0, 1, 0, 0, 0, c(3));
    step(2, 1, 1, 1, 0, 0, c(0));

    stim_done = 1'b1;
  end

  // final report with a bounded drain of the scoreboard
  initial begin
    int waited;
    wait (stim_done);
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited = waited + 1;
    end
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
